// File: rtl/mips_mem_pkg.sv
// Shared types and encodings for the MEM-stage byte-port access unit.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [1:0] MEM_NONE = 2'd0;
    localparam logic [1:0] MEM_LW   = 2'd1;
    localparam logic [1:0] MEM_LH   = 2'd2;
    localparam logic [1:0] MEM_LHU  = 2'd3;

    // Number of byte beats a request needs: half-word loads take two, everything else four.
    function automatic logic [2:0] beat_count(input logic [1:0] mem_read);
        return (mem_read == MEM_LH || mem_read == MEM_LHU) ? 3'd4 - 3'd2 : 3'd4;
    endfunction

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Sign/zero extension of an assembled big-endian load value.
module load_extend
    import mips_mem_pkg::*;
(
    input  logic [31:0] assembled,
    input  logic [1:0]  load_type,
    output logic [31:0] data
);

    // Half-word loads keep the low 16 bits and extend from bit 15.
    always_comb begin
        data = assembled;
        case (load_type)
            MEM_LH:  data = {{16{assembled[15]}}, assembled[15:0]};
            MEM_LHU: data = {16'h0000, assembled[15:0]};
            default: data = assembled;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Serializes one lw/lh/lhu/sw request into big-endian byte beats on the data memory port.
module mem_access_unit
    import mips_mem_pkg::*;
#(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic        req_mem_write,
    input  logic [1:0]  req_mem_read,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_wdata,
    output logic        bus_we,
    output logic        bus_re,
    input  logic [7:0]  bus_rdata
);

    state_t      state;
    logic [1:0]  beat;
    logic [1:0]  last_beat;
    logic [1:0]  load_type;
    logic        is_store;
    logic [31:0] base;
    logic [31:0] wdata_shift;
    logic [31:0] load_shift;

    logic [2:0]  req_beats;
    logic        misaligned;
    logic        out_of_range;
    logic        illegal;
    logic        accept;
    logic [31:0] assembled;
    logic [31:0] extended;

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);

    // Legality of the request currently presented; evaluated only at acceptance.
    always_comb begin
        req_beats    = beat_count(req_mem_read);
        misaligned   = (req_beats == 3'd4) ? (req_addr[1:0] != 2'b00) : req_addr[0];
        out_of_range = ({1'b0, req_addr} + 33'(req_beats)) > 33'(MEM_BYTES);
        illegal      = misaligned || out_of_range || (req_mem_write && req_mem_read != MEM_NONE);
        accept       = req_valid && (state == IDLE) && (req_mem_write || req_mem_read != MEM_NONE);
    end

    // The final read byte arrives during DRAIN and is merged here without waiting a cycle.
    assign assembled = {load_shift[23:0], bus_rdata};

    load_extend u_load_extend (
        .assembled (assembled),
        .load_type (load_type),
        .data      (extended)
    );

    // Control FSM with registered bus strobes and response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            beat        <= 2'd0;
            last_beat   <= 2'd0;
            load_type   <= MEM_NONE;
            is_store    <= 1'b0;
            base        <= 32'd0;
            wdata_shift <= 32'd0;
            load_shift  <= 32'd0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_data   <= 32'd0;
            bus_addr    <= 32'd0;
            bus_wdata   <= 8'd0;
            bus_we      <= 1'b0;
            bus_re      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        load_type  <= req_mem_read;
                        is_store   <= req_mem_write;
                        base       <= req_addr;
                        beat       <= 2'd0;
                        last_beat  <= 2'(req_beats - 3'd1);
                        load_shift <= 32'd0;
                        if (illegal) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_data  <= 32'd0;
                        end else begin
                            state       <= XFER;
                            bus_addr    <= req_addr;
                            bus_we      <= req_mem_write;
                            bus_re      <= !req_mem_write;
                            bus_wdata   <= req_mem_write ? req_wdata[31:24] : 8'd0;
                            wdata_shift <= req_wdata << 8;
                        end
                    end
                end
                XFER: begin
                    // Byte from the previous beat's read is on bus_rdata now.
                    if (beat != 2'd0) begin
                        load_shift <= {load_shift[23:0], bus_rdata};
                    end
                    if (beat == last_beat) begin
                        bus_we <= 1'b0;
                        bus_re <= 1'b0;
                        beat   <= 2'd0;
                        if (is_store) begin
                            state      <= DONE;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_data  <= 32'd0;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        beat        <= beat + 2'd1;
                        bus_addr    <= base + 32'(beat) + 32'd1;
                        bus_wdata   <= is_store ? wdata_shift[31:24] : 8'd0;
                        wdata_shift <= wdata_shift << 8;
                    end
                end
                DRAIN: begin
                    state      <= DONE;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_data  <= extended;
                end
                DONE: begin
                    state      <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_data  <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
